fetch_queue: RTL
================

# fetch_queue

Dual-slot in-order instruction queue between the frontend pre-decode outputs (fetch0/fetch1) and the issue stage. It absorbs issue back-pressure so the fetch/decode pipe keeps streaming. It accepts up to two instructions per cycle and delivers up to two per cycle in program order. It is cleared on a branch/exception redirect.

## Interface
- DEPTH, 8: number of entries; power of two, >= 4.
- DEPTH_W, 3: log2(DEPTH).
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  redirect (branch_request from issue); discards all contents.
- in0_valid_i  in  1  older incoming instruction valid.
- in0_instr_i  in  32  instruction word.
- in0_pc_i  in  32  instruction PC.
- in0_info_i  in  12  {fault_fetch, fault_page, invalid, exec, lsu, branch, mul, div, csr, rs1_valid, rs2_valid, rd_valid}.
- in0_accept_o  out  1  slot 0 can be written.
- in1_valid_i / in1_instr_i / in1_pc_i / in1_info_i  in  1/32/32/12  younger incoming instruction.
- in1_accept_o  out  1  slot 1 can be written.
- out0_valid_o / out0_instr_o / out0_pc_o / out0_info_o  out  1/32/32/12  oldest queued instruction.
- out0_accept_i  in  1  issue takes out0.
- out1_valid_o / out1_instr_o / out1_pc_o / out1_info_o  out  1/32/32/12  second-oldest queued instruction.
- out1_accept_i  in  1  issue takes out1.
- count_o  out  DEPTH_W+1  current occupancy, registered.

## Operation
- Storage: circular buffer of DEPTH entries of 76 bits. Write pointer wr_ptr, read pointer rd_ptr (DEPTH_W bits, natural wrap), and count (DEPTH_W+1 bits).
- Accept signals are derived only from the registered count and do not depend on same-cycle pops:
  - in0_accept_o = !flush_i && count <= DEPTH-1.
  - in1_accept_o = !flush_i && count <= DEPTH-2.
- Push, with writes compacted in order:
  - p0 = in0_valid_i & in0_accept_o.
  - p1 = in1_valid_i & in1_accept_o.
  - If p0 is set: in0 is written at wr_ptr, and in1 (if p1) at wr_ptr+1.
  - If p0 is clear and p1 is set: in1 is written at wr_ptr.
  - push = p0+p1.
- Output presentation:
  - out0 = entry[rd_ptr], with out0_valid_o = count>=1 && !flush_i.
  - out1 = entry[rd_ptr+1], with out1_valid_o = count>=2 && !flush_i.
- Pop is strictly in order:
  - q0 = out0_valid_o & out0_accept_i.
  - q1 = q0 & out1_valid_o & out1_accept_i. out1_accept_i without out0_accept_i is ignored.
  - pop = q0+q1.
- Update:
  - wr_ptr += push.
  - rd_ptr += pop.
  - count = count + push - pop. This never exceeds DEPTH or goes below 0.
- Flush: wr_ptr, rd_ptr and count go to 0 on the next edge. Same-cycle pushes and pops are discarded because accepts and valids are gated by flush_i.
- Reset: identical to flush; entry contents are not cleared.

## Timing
- All outputs are registered-state derived, except the flush_i gating, which is a combinational AND.
- Reset values: count_o=0, out0_valid_o=0, out1_valid_o=0, in0_accept_o=1, in1_accept_o=1. Data outputs are don't-care.
- Latency without bypass: an instruction written at edge N is visible on out0 in cycle N+1.
- Throughput: 2 in / 2 out per cycle sustained when count stays between 2 and DEPTH-2.
- Full (count==DEPTH): both accepts are 0 even if issue pops in the same cycle. The accepts reopen one cycle later.
- count==DEPTH-1: only in0 is accepted. in1 must be held by the upstream stage.
- Empty: both out valids are 0. A simultaneous push is visible next cycle, unless bypass is enabled.
- Pointer wrap at DEPTH-1 -> 0 is seamless; out1 reads entry[0] when rd_ptr==DEPTH-1.
- Reset asserted mid-stream: the state is cleared at that edge and reset dominates flush and push.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count==0 and !flush_i, out0/out1 present in0/in1 combinationally, with valid = in*_valid_i.
  - Bypassed instructions that issue accepts are not written.
  - Bypassed instructions that are not accepted are written normally.
  - Zero-cycle latency when empty.
- Not defined: no input-to-output combinational path; minimum latency is 1 cycle.

## Test plan
- Reset, then push in0=0x00000013/pc 0x80000000 and in1=0x00100093/pc 0x80000004 with out accepts low -> next cycle count_o=2, out0_pc_o=0x80000000, out1_pc_o=0x80000004.
- Fill 8 entries with out accepts held low -> count_o=8, in0_accept_o=0. Pop both in the same cycle -> accepts still 0 that cycle; next cycle count_o=6 and in0_accept_o=in1_accept_o=1.
- count=7, both inputs valid -> only in0 is stored, count_o=8, and in1 is not taken.
- Assert out1_accept_i=1 with out0_accept_i=0 while count=3 -> no pop, count_o stays 3.
- Stream 20 instructions across pointer wrap with random accepts -> output PCs are strictly increasing by 4 with no loss or duplication.
- Queue holding 5 entries, pulse flush_i with both inputs valid -> accepts and out valids are 0 that cycle, and count_o=0 next cycle. With FETCH_QUEUE_BYPASS_EN, the empty-queue push appears on out0 in the same cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Dual-slot in-order instruction queue sitting between the frontend
//   pre-decode outputs and the issue stage. Accepts up to two instructions
//   per cycle, delivers up to two per cycle in program order, and is cleared
//   by a branch/exception redirect (flush_i).
//
// Parameters
//   DEPTH    number of entries (power of two, >= 4)
//   DEPTH_W  log2(DEPTH)
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                redirect: discard all contents
//   in0_* / in1_*          older / younger incoming instruction
//                          (valid, instr[31:0], pc[31:0], info[11:0])
//   in0_accept_o           slot 0 can be written
//   in1_accept_o           slot 1 can be written
//   out0_* / out1_*        oldest / second-oldest queued instruction
//   out0_accept_i          issue takes out0
//   out1_accept_i          issue takes out1 (ignored unless out0 is taken)
//   count_o                registered occupancy
//
// Build option
//   FETCH_QUEUE_BYPASS_EN  when defined, an empty queue presents in0/in1 on
//                          out0/out1 combinationally (zero-cycle latency);
//                          bypassed instructions taken by issue are not
//                          written. Undefined: no input-to-output path.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,

    input  logic               in0_valid_i,
    input  logic [31:0]        in0_instr_i,
    input  logic [31:0]        in0_pc_i,
    input  logic [11:0]        in0_info_i,
    output logic               in0_accept_o,

    input  logic               in1_valid_i,
    input  logic [31:0]        in1_instr_i,
    input  logic [31:0]        in1_pc_i,
    input  logic [11:0]        in1_info_i,
    output logic               in1_accept_o,

    output logic               out0_valid_o,
    output logic [31:0]        out0_instr_o,
    output logic [31:0]        out0_pc_o,
    output logic [11:0]        out0_info_o,
    input  logic               out0_accept_i,

    output logic               out1_valid_o,
    output logic [31:0]        out1_instr_o,
    output logic [31:0]        out1_pc_o,
    output logic [11:0]        out1_info_o,
    input  logic               out1_accept_i,

    output logic [DEPTH_W:0]   count_o
);

    localparam int ENTRY_W = 76;
    localparam logic [DEPTH_W:0] CNT_FULL_M1 = (DEPTH_W+1)'(DEPTH - 1);
    localparam logic [DEPTH_W:0] CNT_FULL_M2 = (DEPTH_W+1)'(DEPTH - 2);

    // Entry layout: {info, pc, instr}
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [DEPTH_W-1:0] r_wr_ptr;
    logic [DEPTH_W-1:0] r_rd_ptr;
    logic [DEPTH_W:0]   r_count;

    logic               w_p0, w_p1;
    logic               w_q0, w_q1;
    logic               w_wr0, w_wr1;
    logic               w_bypass;
    logic [DEPTH_W:0]   w_push;
    logic [DEPTH_W:0]   w_pop;
    logic [DEPTH_W-1:0] w_wr_idx1;
    logic [DEPTH_W-1:0] w_rd_idx1;
    logic [ENTRY_W-1:0] w_in0_entry, w_in1_entry;
    logic [ENTRY_W-1:0] w_head0, w_head1;

    assign w_in0_entry = {in0_info_i, in0_pc_i, in0_instr_i};
    assign w_in1_entry = {in1_info_i, in1_pc_i, in1_instr_i};

    // Accepts look only at the registered count: a full queue stays closed
    // for one cycle even if issue drains it in that same cycle.
    assign in0_accept_o = !flush_i && (r_count <= CNT_FULL_M1);
    assign in1_accept_o = !flush_i && (r_count <= CNT_FULL_M2);

    assign w_p0 = in0_valid_i & in0_accept_o;
    assign w_p1 = in1_valid_i & in1_accept_o;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) && !flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    // Output presentation
    assign w_rd_idx1 = r_rd_ptr + 1'b1;
    assign w_head0   = r_mem[r_rd_ptr];
    assign w_head1   = r_mem[w_rd_idx1];

    always_comb begin
        if (w_bypass) begin
            out0_valid_o = in0_valid_i;
            out1_valid_o = in1_valid_i;
            {out0_info_o, out0_pc_o, out0_instr_o} = w_in0_entry;
            {out1_info_o, out1_pc_o, out1_instr_o} = w_in1_entry;
        end else begin
            out0_valid_o = !flush_i && (r_count != '0);
            out1_valid_o = !flush_i && (r_count > (DEPTH_W+1)'(1));
            {out0_info_o, out0_pc_o, out0_instr_o} = w_head0;
            {out1_info_o, out1_pc_o, out1_instr_o} = w_head1;
        end
    end

    // In-order pop: out1 can only leave together with out0
    assign w_q0 = out0_valid_o & out0_accept_i;
    assign w_q1 = w_q0 & out1_valid_o & out1_accept_i;

    // A bypassed instruction that issue takes never enters storage; any
    // that is not taken is written as a normal push.
    assign w_wr0 = w_p0 & ~(w_bypass & w_q0);
    assign w_wr1 = w_p1 & ~(w_bypass & w_q1);

    assign w_push = (DEPTH_W+1)'(w_wr0) + (DEPTH_W+1)'(w_wr1);
    assign w_pop  = w_bypass ? '0 : ((DEPTH_W+1)'(w_q0) + (DEPTH_W+1)'(w_q1));

    // Compacted writes: in1 lands right after in0, or at wr_ptr if in0 idle
    assign w_wr_idx1 = r_wr_ptr + DEPTH_W'(w_wr0);

    // Storage is never reset; validity is tracked solely by count.
    always_ff @(posedge clk_i) begin
        if (w_wr0) r_mem[r_wr_ptr]  <= w_in0_entry;
        if (w_wr1) r_mem[w_wr_idx1] <= w_in1_entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push[DEPTH_W-1:0];
            r_rd_ptr <= r_rd_ptr + w_pop[DEPTH_W-1:0];
            r_count  <= r_count + w_push - w_pop;
        end
    end

    assign count_o = r_count;

endmodule
